// File: rtl/regfile_scoreboard.sv
// Integer register file for the pipelined core: two combinational read ports, one write-back
// port, same-cycle write-back bypass and a per-register pending scoreboard for RAW/WAW detection.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs1_ready_o,
  output logic            rs2_ready_o,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  output logic            issue_ready_o,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [AW:0]     pending_cnt_o,
  output logic            wb_err_o
);

  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] pending;
  logic [AW:0]      pending_cnt;
  logic             wb_err;

  logic             wb_hit1, wb_hit2, wb_hit_issue;
  logic             set_en, set_new, clr_eff, wr_en;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] a, input logic [XLEN-1:0] word,
                                              input logic hit, input logic [XLEN-1:0] wb_word);
    if (is_zero(a))               return '0;
    else if ((BYPASS != 0) && hit) return wb_word;
    else                           return word;
  endfunction

  always_comb begin
    wb_hit1      = wb_valid_i && (wb_rd_i == rs1_addr_i);
    wb_hit2      = wb_valid_i && (wb_rd_i == rs2_addr_i);
    wb_hit_issue = wb_valid_i && (wb_rd_i == issue_rd_i);

    rs1_data_o   = read_mux(rs1_addr_i, mem[rs1_addr_i], wb_hit1, wb_data_i);
    rs2_data_o   = read_mux(rs2_addr_i, mem[rs2_addr_i], wb_hit2, wb_data_i);

    rs1_ready_o  = is_zero(rs1_addr_i) || !pending[rs1_addr_i] || ((BYPASS != 0) && wb_hit1);
    rs2_ready_o  = is_zero(rs2_addr_i) || !pending[rs2_addr_i] || ((BYPASS != 0) && wb_hit2);

    // A write-back retiring the same register frees it for a new producer in the same cycle.
    issue_ready_o = is_zero(issue_rd_i) || !pending[issue_rd_i] || wb_hit_issue;

    set_en  = issue_valid_i && issue_ready_o && !is_zero(issue_rd_i);
    set_new = set_en && !pending[issue_rd_i];
    // Clearing a bit only counts when it was set and is not immediately re-set by an issue.
    clr_eff = wb_valid_i && pending[wb_rd_i] && !(set_en && (issue_rd_i == wb_rd_i));
    wr_en   = wb_valid_i && !is_zero(wb_rd_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      pending     <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wb_rd_i] <= wb_data_i;
        if (!pending[wb_rd_i]) wb_err <= 1'b1;
      end
      if (wb_valid_i) pending[wb_rd_i]    <= 1'b0;
      if (set_en)     pending[issue_rd_i] <= 1'b1;
      pending_cnt <= pending_cnt + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_eff};
    end
  end

  assign pending_cnt_o = pending_cnt;
  assign wb_err_o      = wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: cycle-level behavioural model checked every negedge,
// plus directed expectations from the test plan.
module tb_regfile_scoreboard;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_rd_i, wb_rd_i;
  logic [31:0] rs1_data_o, rs2_data_o, wb_data_i;
  logic        rs1_ready_o, rs2_ready_o, issue_valid_i, issue_ready_o, wb_valid_i, wb_err_o;
  logic [5:0]  pending_cnt_o;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_ready_o(rs1_ready_o), .rs2_ready_o(rs2_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .pending_cnt_o(pending_cnt_o), .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state: architectural value and "has an outstanding producer" per register.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_valid_i && wb_rd_i == a) return wb_data_i;
    return m_mem[a];
  endfunction

  function automatic logic exp_ready(input logic [4:0] a);
    return (a == 0) || !m_pend[a] || (wb_valid_i && wb_rd_i == a);
  endfunction

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= 32'h0;
        m_pend[i] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      if (wb_valid_i && wb_rd_i != 0) begin
        m_mem[wb_rd_i] <= wb_data_i;
        if (!m_pend[wb_rd_i]) m_err <= 1'b1;
        m_pend[wb_rd_i] <= 1'b0;
      end
      // Later nonblocking write wins: a same-register issue keeps the bit set.
      if (issue_valid_i && exp_ready(issue_rd_i) && issue_rd_i != 0)
        m_pend[issue_rd_i] <= 1'b1;
    end
  end

  always @(negedge clk_i) begin
    chk("rs1_data",    rs1_data_o,            exp_data(rs1_addr_i));
    chk("rs2_data",    rs2_data_o,            exp_data(rs2_addr_i));
    chk("rs1_ready",   32'(rs1_ready_o),      32'(exp_ready(rs1_addr_i)));
    chk("rs2_ready",   32'(rs2_ready_o),      32'(exp_ready(rs2_addr_i)));
    chk("issue_ready", 32'(issue_ready_o),    32'(exp_ready(issue_rd_i)));
    chk("pending_cnt", 32'(pending_cnt_o),    32'(popcount()));
    chk("wb_err",      32'(wb_err_o),         32'(m_err));
  end

  task automatic drive(input logic iv, input logic [4:0] ird, input logic wv, input logic [4:0] wrd,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk_i);
    #1;
    issue_valid_i = iv; issue_rd_i = ird;
    wb_valid_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    rs1_addr_i = a1; rs2_addr_i = a2;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0;
    issue_valid_i = 0; issue_rd_i = 0; wb_valid_i = 0; wb_rd_i = 0; wb_data_i = 0;
    rs1_addr_i = 5; rs2_addr_i = 7;
    #12;
    chk("rst_rs1_data",  rs1_data_o, 32'h0);
    chk("rst_rs1_ready", 32'(rs1_ready_o), 32'd1);
    chk("rst_issue_rdy", 32'(issue_ready_o), 32'd1);
    chk("rst_cnt",       32'(pending_cnt_o), 32'd0);
    chk("rst_err",       32'(wb_err_o), 32'd0);
    #10 rst_i = 1'b1;

    // Bypass then array read of x5, sticky error for unpended write-back.
    drive(0, 0, 1, 5, 32'hDEAD_BEEF, 5, 0);
    chk("bypass_x5", rs1_data_o, 32'hDEAD_BEEF);
    chk("err_before", 32'(wb_err_o), 32'd0);
    drive(0, 0, 0, 0, 0, 5, 0);
    chk("array_x5", rs1_data_o, 32'hDEAD_BEEF);
    chk("err_after", 32'(wb_err_o), 32'd1);

    // x0 hardwired.
    drive(1, 0, 1, 0, 32'h1234, 0, 0);
    chk("x0_bypass", rs1_data_o, 32'h0);
    chk("x0_ready", 32'(rs1_ready_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("x0_cnt", 32'(pending_cnt_o), 32'd0);
    chk("x0_data", rs1_data_o, 32'h0);

    // RAW / WAW on x7.
    drive(1, 7, 0, 0, 0, 0, 7);
    chk("x7_issue_ok", 32'(issue_ready_o), 32'd1);
    drive(1, 7, 0, 0, 0, 0, 7);
    chk("x7_rs2_busy", 32'(rs2_ready_o), 32'd0);
    chk("x7_cnt1", 32'(pending_cnt_o), 32'd1);
    chk("x7_waw", 32'(issue_ready_o), 32'd0);
    drive(0, 0, 1, 7, 32'hAA, 0, 7);
    chk("x7_cnt_hold", 32'(pending_cnt_o), 32'd1);
    chk("x7_wb_ready", 32'(rs2_ready_o), 32'd1);
    chk("x7_wb_data", rs2_data_o, 32'hAA);
    drive(0, 0, 0, 0, 0, 0, 7);
    chk("x7_cnt0", 32'(pending_cnt_o), 32'd0);
    chk("x7_array", rs2_data_o, 32'hAA);

    // Same-cycle issue and write-back of x9: set wins.
    drive(1, 9, 0, 0, 0, 9, 0);
    drive(1, 9, 1, 9, 32'h55, 9, 0);
    chk("x9_issue_ok", 32'(issue_ready_o), 32'd1);
    chk("x9_bypass", rs1_data_o, 32'h55);
    drive(0, 0, 0, 0, 0, 9, 0);
    chk("x9_pending", 32'(rs1_ready_o), 32'd0);
    chk("x9_cnt", 32'(pending_cnt_o), 32'd1);
    chk("x9_data", rs1_data_o, 32'h55);
    drive(0, 0, 1, 9, 32'h55, 9, 0);
    drive(0, 0, 0, 0, 0, 9, 0);
    chk("x9_cnt0", 32'(pending_cnt_o), 32'd0);

    // Fill every register, then drain.
    for (int r = 1; r < 32; r++) drive(1, 5'(r), 0, 0, 0, 5'(r), 1);
    drive(0, 31, 0, 0, 0, 0, 0);
    chk("full_cnt", 32'(pending_cnt_o), 32'd31);
    chk("full_waw", 32'(issue_ready_o), 32'd0);
    for (int r = 1; r < 32; r++) drive(0, 0, 1, 5'(r), 32'(r * 3), 5'(r), 0);
    drive(0, 0, 0, 0, 0, 31, 0);
    chk("drain_cnt", 32'(pending_cnt_o), 32'd0);
    chk("drain_x31", rs1_data_o, 32'd93);

    // Asynchronous reset mid-operation.
    drive(0, 0, 1, 3, 32'hFFFF_FFFF, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 3, 1);
    drive(0, 3, 0, 0, 0, 3, 1);
    chk("pre_rst_cnt", 32'(pending_cnt_o), 32'd3);
    chk("pre_rst_x3", rs1_data_o, 32'hFFFF_FFFF);
    chk("pre_rst_busy", 32'(rs1_ready_o), 32'd0);
    #1 rst_i = 1'b0;
    #1;
    chk("arst_cnt", 32'(pending_cnt_o), 32'd0);
    chk("arst_err", 32'(wb_err_o), 32'd0);
    chk("arst_x3", rs1_data_o, 32'h0);
    chk("arst_ready", 32'(rs1_ready_o), 32'd1);
    chk("arst_issue", 32'(issue_ready_o), 32'd1);
    #1 rst_i = 1'b1;
    drive(0, 2, 0, 0, 0, 3, 1);
    chk("post_x3", rs1_data_o, 32'h0);
    chk("post_rdy1", 32'(rs1_ready_o), 32'd1);
    chk("post_rdy2", 32'(rs2_ready_o), 32'd1);
    chk("post_issue", 32'(issue_ready_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
